// File: rtl/ram_burst_reader.sv
// Burst reader: streams RAM words [start..end] out as a valid/ready stream with a last flag.
// Define RAM_BURST_READER_HEADER_EN to prefix each burst with an {end,start} header beat.
module ram_burst_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_start_addr,
  input  logic [ADDR_W-1:0] cmd_end_addr,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              cmd_err
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   remaining;
  logic              vld_p1, last_p1;
  logic [OUT_W-1:0]  fifo_data [2];
  logic [1:0]        fifo_last;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic              accept, cmd_bad, pop, issue_room;
  logic              hdr_wr, wr_en, wr_last;
  logic [OUT_W-1:0]  wr_data, hdr_word;

  function automatic logic [OUT_W-1:0] zero_ext(input logic [DATA_W-1:0] d);
    return OUT_W'(d);
  endfunction

`ifdef RAM_BURST_READER_HEADER_EN
  function automatic logic [OUT_W-1:0] build_header(input logic [ADDR_W-1:0] s,
                                                    input logic [ADDR_W-1:0] e);
    logic [15:0] s16, e16;
    s16 = 16'(s);
    e16 = 16'(e);
    return OUT_W'({e16, s16});
  endfunction
  assign hdr_word = build_header(cmd_start_addr, cmd_end_addr);
  assign hdr_wr   = accept & ~cmd_bad;
`else
  assign hdr_word = '0;
  assign hdr_wr   = 1'b0;
`endif

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (count != 2'd0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_last  = fifo_last[rd_ptr];
  assign ram_addr  = rd_addr;

  assign accept  = cmd_valid & cmd_ready;
  assign cmd_bad = (cmd_end_addr < cmd_start_addr);
  assign pop     = out_valid & out_ready;
  // A slot freed by this cycle's pop may be reused, which is what allows 1 beat/cycle.
  assign issue_room = ((count + {1'b0, vld_p1} - {1'b0, pop}) < 2'd2);

  assign wr_en   = vld_p1 | hdr_wr;
  assign wr_last = last_p1 & ~hdr_wr;
  assign wr_data = hdr_wr ? hdr_word : zero_ext(ram_dout);

  always_comb begin
    state_d = state_q;
    ram_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && !cmd_bad) state_d = S_READ;
      end
      S_READ: begin
        if ((remaining != '0) && issue_room) begin
          ram_en = 1'b1;
          if (remaining == REM_ONE) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && out_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      rd_addr      <= '0;
      remaining    <= '0;
      vld_p1       <= 1'b0;
      last_p1      <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= '0;
      cmd_err      <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_err <= accept & cmd_bad;
      // Stage p0 -> p1: read issued this cycle, its data is captured next cycle
      vld_p1  <= ram_en;
      if (accept && !cmd_bad) begin
        rd_addr   <= cmd_start_addr;
        remaining <= {1'b0, cmd_end_addr} - {1'b0, cmd_start_addr} + REM_ONE;
      end else if (ram_en) begin
        remaining <= remaining - REM_ONE;
        last_p1   <= (remaining == REM_ONE);
        // Hold on the final address so the pointer never wraps past 1023.
        if (remaining != REM_ONE) rd_addr <= rd_addr + 1'b1;
      end
      // Stage p1 -> buffer
      if (wr_en) begin
        fifo_data[wr_ptr] <= wr_data;
        fifo_last[wr_ptr] <= wr_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, wr_en} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader: randomized and directed bursts against a queue model.
module tb_ram_burst_reader;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int OUT_W  = 32;

  logic              clk = 1'b0;
  logic              rstn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_start_addr;
  logic [ADDR_W-1:0] cmd_end_addr;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              cmd_err;

  ram_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start_addr(cmd_start_addr), .cmd_end_addr(cmd_end_addr),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // RAM model: mem[i] = i + 0x100, one-cycle read latency
  logic [DATA_W-1:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i + 'h100);
    ram_dout = '0;
  end
  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int hdr_beats;
`ifdef RAM_BURST_READER_HEADER_EN
  initial hdr_beats = 1;
`else
  initial hdr_beats = 0;
`endif

  // Occupancy and address monitors: entries committed = reads issued + headers - pops
  int lo_addr = 0, hi_addr = 1023;
  int addr_err = 0, over_err = 0, pend = 0, nxt_pend;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) pend = 0;
    else begin
      nxt_pend = pend + (ram_en ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      if (hdr_beats != 0 && cmd_valid && cmd_ready && (cmd_end_addr >= cmd_start_addr))
        nxt_pend = nxt_pend + 1;
      if (ram_en && (int'(ram_addr) < lo_addr || int'(ram_addr) > hi_addr)) addr_err++;
      if (nxt_pend > 2) over_err++;
      pend = nxt_pend;
    end
  end

  logic [31:0] exp_data [$];
  bit          exp_last [$];
  logic [31:0] obs_data [$];
  bit          obs_last [$];
  int          obs_cyc  [$];
  int acc_cyc, first_vld_cyc, stall_err, timed_out;
  logic busy_after, rdy_after, busy_at_acc, rdy_at_acc;

  task automatic build_expected(input int s, input int e);
    exp_data.delete();
    exp_last.delete();
    if (hdr_beats != 0) begin
      exp_data.push_back((32'(e) << 16) | 32'(s));
      exp_last.push_back(1'b0);
    end
    for (int a = s; a <= e; a++) begin
      exp_data.push_back(32'(a + 'h100));
      exp_last.push_back(a == e);
    end
  endtask

  // mode: 0 = ready always high, 1 = toggling, 2 = random
  task automatic run_burst(input int s, input int e, input int mode, input int max_cyc);
    logic        prev_stall, pl, done;
    logic [31:0] pd;
    obs_data.delete(); obs_last.delete(); obs_cyc.delete();
    stall_err = 0; timed_out = 1; first_vld_cyc = -1; done = 1'b0;
    lo_addr = s; hi_addr = e;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_start_addr = ADDR_W'(s);
    cmd_end_addr = ADDR_W'(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    acc_cyc = cyc;
    busy_at_acc = busy;
    rdy_at_acc = cmd_ready;
    prev_stall = 1'b0; pd = '0; pl = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      if (prev_stall && (!out_valid || out_data !== pd || out_last !== pl)) stall_err++;
      if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = n[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      prev_stall = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
      if (out_valid && out_ready) begin
        obs_data.push_back(out_data);
        obs_last.push_back(out_last);
        obs_cyc.push_back(cyc);
        if (out_last) done = 1'b1;
      end
      @(negedge clk);
      if (done) begin
        busy_after = busy;
        rdy_after = cmd_ready;
        timed_out = 0;
        break;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; cmd_valid = 1'b0; cmd_start_addr = '0; cmd_end_addr = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cmd_ready, ram_en, ram_addr, out_valid, out_data, out_last, busy, cmd_err} !==
        {1'b1, 1'b0, 10'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b en=%0b addr=%0d vld=%0b data=%h last=%0b busy=%0b err=%0b, want rdy=1 rest 0",
               cmd_ready, ram_en, ram_addr, out_valid, out_data, out_last, busy, cmd_err);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    build_expected(5, 8);
    run_burst(5, 8, 0, 40);
    checks++;
    if (timed_out != 0) begin errors++; $display("FAIL basic_timeout: no last beat within budget"); end
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      errors++; $display("FAIL basic_count: got %0d beats, want %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
        errors++; $display("FAIL basic_beat%0d: got %h/%0b, want %h/%0b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
      end
    end
    checks++;
    if (first_vld_cyc - acc_cyc != 2 - 2 * hdr_beats) begin
      errors++; $display("FAIL basic_latency: first valid after %0d cycles, want %0d", first_vld_cyc - acc_cyc, 2 - 2 * hdr_beats);
    end
    checks++;
    if (obs_cyc.size() == 4 + hdr_beats && obs_cyc[3 + hdr_beats] - obs_cyc[hdr_beats] != 3) begin
      errors++; $display("FAIL basic_throughput: data beats spanned %0d cycles, want 3", obs_cyc[3 + hdr_beats] - obs_cyc[hdr_beats]);
    end
    checks++;
    if ({busy_at_acc, rdy_at_acc, busy_after, rdy_after} !== 4'b1001) begin
      errors++; $display("FAIL basic_busy: during busy=%0b rdy=%0b after busy=%0b rdy=%0b, want 1 0 0 1",
                         busy_at_acc, rdy_at_acc, busy_after, rdy_after);
    end
  endtask

  task automatic test_single_top();
    build_expected(1023, 1023);
    run_burst(1023, 1023, 0, 40);
    checks++;
    if (timed_out != 0 || obs_data.size() != exp_data.size()) begin
      errors++; $display("FAIL single_count: got %0d beats (timeout=%0d), want %0d", obs_data.size(), timed_out, exp_data.size());
    end else begin
      checks++;
      if (obs_data[hdr_beats] !== 32'h0000_04FF || obs_last[hdr_beats] !== 1'b1) begin
        errors++; $display("FAIL single_beat: got %h/%0b, want 000004ff/1", obs_data[hdr_beats], obs_last[hdr_beats]);
      end
    end
    checks++;
    if (addr_err != 0) begin errors++; $display("FAIL single_addr: %0d out-of-range reads, want 0", addr_err); end
  endtask

  task automatic test_full_toggle();
    int bad;
    build_expected(0, 1023);
    run_burst(0, 1023, 1, 6000);
    checks++;
    if (timed_out != 0 || obs_data.size() != exp_data.size()) begin
      errors++; $display("FAIL full_count: got %0d beats (timeout=%0d), want %0d", obs_data.size(), timed_out, exp_data.size());
    end
    bad = 0;
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++)
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL full_order: %0d beats wrong, want 0", bad); end
    checks++;
    if (stall_err != 0) begin errors++; $display("FAIL full_stall_stable: %0d unstable stalls, want 0", stall_err); end
    checks++;
    if (over_err != 0 || addr_err != 0) begin
      errors++; $display("FAIL full_issue_rule: overcommit=%0d badaddr=%0d, want 0 0", over_err, addr_err);
    end
  endtask

  task automatic test_reject();
    int vld_seen;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_start_addr = 10'd9; cmd_end_addr = 10'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({cmd_err, cmd_ready, busy} !== 3'b110) begin
      errors++; $display("FAIL reject_pulse: err=%0b rdy=%0b busy=%0b, want 1 1 0", cmd_err, cmd_ready, busy);
    end
    vld_seen = 0;
    @(negedge clk);
    checks++;
    if (cmd_err !== 1'b0) begin errors++; $display("FAIL reject_width: cmd_err=%0b in second cycle, want 0", cmd_err); end
    for (int i = 0; i < 5; i++) begin
      if (out_valid || busy || !cmd_ready) vld_seen++;
      @(negedge clk);
    end
    checks++;
    if (vld_seen != 0) begin errors++; $display("FAIL reject_quiet: %0d cycles with activity, want 0", vld_seen); end
  endtask

  task automatic test_reset_mid();
    int got;
    bit hit;
    lo_addr = 0; hi_addr = 9;
    got = 0; hit = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_start_addr = 10'd0; cmd_end_addr = 10'd9;
    @(negedge clk);
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      if (out_valid && got == 1 + hdr_beats) begin hit = 1; break; end
      if (out_valid) got++;
      @(negedge clk);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL midreset_reach: second beat not seen, got %0d beats", got); end
    rstn = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, ram_en, ram_addr, out_valid, out_data, out_last, busy, cmd_err} !==
        {1'b1, 1'b0, 10'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_state: rdy=%0b en=%0b addr=%0d vld=%0b data=%h last=%0b busy=%0b, want rdy=1 rest 0",
               cmd_ready, ram_en, ram_addr, out_valid, out_data, out_last, busy);
    end
    out_ready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    build_expected(0, 1);
    run_burst(0, 1, 0, 40);
    checks++;
    if (timed_out != 0 || obs_data.size() != exp_data.size()) begin
      errors++; $display("FAIL midreset_count: got %0d beats (timeout=%0d), want %0d", obs_data.size(), timed_out, exp_data.size());
    end
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
        errors++; $display("FAIL midreset_beat%0d: got %h/%0b, want %h/%0b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_random();
    int s, e, bad;
    for (int k = 0; k < 8; k++) begin
      s = int'($urandom_range(0, 1023));
      e = s + int'($urandom_range(0, 47));
      if (e > 1023) e = 1023;
      build_expected(s, e);
      run_burst(s, e, 2, 400);
      bad = 0;
      for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++)
        if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) bad++;
      checks++;
      if (timed_out != 0 || obs_data.size() != exp_data.size() || bad != 0 || stall_err != 0) begin
        errors++;
        $display("FAIL random%0d [%0d..%0d]: beats=%0d want %0d, wrong=%0d, stall=%0d, timeout=%0d",
                 k, s, e, obs_data.size(), exp_data.size(), bad, stall_err, timed_out);
      end
    end
    checks++;
    if (over_err != 0 || addr_err != 0) begin
      errors++; $display("FAIL random_issue_rule: overcommit=%0d badaddr=%0d, want 0 0", over_err, addr_err);
    end
  endtask

`ifdef RAM_BURST_READER_HEADER_EN
  task automatic test_header();
    logic [31:0] want [4];
    want[0] = 32'h0004_0002; want[1] = 32'h102; want[2] = 32'h103; want[3] = 32'h104;
    run_burst(2, 4, 0, 40);
    checks++;
    if (timed_out != 0 || obs_data.size() != 4) begin
      errors++; $display("FAIL header_count: got %0d beats (timeout=%0d), want 4", obs_data.size(), timed_out);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_data[i] !== want[i] || obs_last[i] !== (i == 3)) begin
          errors++; $display("FAIL header_beat%0d: got %h/%0b, want %h/%0b", i, obs_data[i], obs_last[i], want[i], i == 3);
        end
      end
      checks++;
      if (obs_cyc[1] - acc_cyc != 2) begin
        errors++; $display("FAIL header_latency: first data after %0d cycles, want 2", obs_cyc[1] - acc_cyc);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_single_top();
    test_reject();
    test_full_toggle();
    test_reset_mid();
    test_random();
`ifdef RAM_BURST_READER_HEADER_EN
    test_header();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
